// File: rtl/fc_layer_sequencer.sv
// -----------------------------------------------------------------------------
// fc_layer_sequencer
//
// Sequential controller for one fully connected layer, Z = W*X + B.
// A single multiply-accumulate path walks the layer neuron by neuron, reading
// bias, input and weight words one at a time from a shared word memory. Each
// neuron is accumulated at full precision, then shifted back to the Q format,
// saturated and written to memory.
//
// Optional feature macro: FC_RELU_EN
//   defined   -> a negative saturated result is written as 0 (fused ReLU)
//   undefined -> the signed saturated result is written unmodified
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle run request, sampled only when idle
//   x_base, w_base,    base addresses of X, W (row-major), B and Z,
//   b_base, z_base     latched when a start is accepted
//   mem_rd_en/addr     read strobe and address (data returns one cycle later)
//   mem_rd_data        read data
//   mem_wr_en/addr/data write strobe, address and data
//   busy               high whenever the sequencer is not idle
//   done               one-cycle pulse after the last neuron is written
// -----------------------------------------------------------------------------
module fc_layer_sequencer #(
    parameter int WORD_SIZE     = 16,
    parameter int IP_LAYER_SIZE = 128,
    parameter int OP_LAYER_SIZE = 84,
    parameter int INT_SLICE     = 8,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] x_base,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] z_base,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WORD_SIZE-1:0]  mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [WORD_SIZE-1:0]  mem_wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int FRAC  = WORD_SIZE - INT_SLICE;
    localparam int ACC_W = 2 * WORD_SIZE + $clog2(IP_LAYER_SIZE);
    localparam int IW    = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;
    localparam int JW    = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(IP_LAYER_SIZE - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OP_LAYER_SIZE - 1);

    // Saturation bounds expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BIAS_RD  = 3'd1,
        ST_BIAS_CAP = 3'd2,
        ST_X_RD     = 3'd3,
        ST_W_RD     = 3'd4,
        ST_MAC      = 3'd5,
        ST_WRITE    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Drop the fraction bits (floor), clamp to the word range, optional ReLU.
    function automatic logic [WORD_SIZE-1:0] scale_sat(input logic signed [ACC_W-1:0] acc_v);
        logic signed [ACC_W-1:0] shifted_v;
        logic [WORD_SIZE-1:0]    res_v;
        shifted_v = acc_v >>> FRAC;
        if (shifted_v > SAT_MAX) begin
            res_v = {1'b0, {(WORD_SIZE-1){1'b1}}};
        end else if (shifted_v < SAT_MIN) begin
            res_v = {1'b1, {(WORD_SIZE-1){1'b0}}};
        end else begin
            res_v = shifted_v[WORD_SIZE-1:0];
        end
`ifdef FC_RELU_EN
        res_v = res_v[WORD_SIZE-1] ? {WORD_SIZE{1'b0}} : res_v;
`endif
        return res_v;
    endfunction

    state_t                   state_r, state_n;
    logic [JW-1:0]            j_r, j_n;
    logic [IW-1:0]            i_r, i_n;
    logic [ADDR_WIDTH-1:0]    wptr_r, wptr_n;
    logic signed [ACC_W-1:0]  acc_r, acc_n;
    logic signed [WORD_SIZE-1:0] x_reg_r, x_reg_n;
    logic [ADDR_WIDTH-1:0]    x_base_r, x_base_n;
    logic [ADDR_WIDTH-1:0]    b_base_r, b_base_n;
    logic [ADDR_WIDTH-1:0]    z_base_r, z_base_n;
    logic                     rd_en_r, rd_en_n;
    logic [ADDR_WIDTH-1:0]    rd_addr_r, rd_addr_n;
    logic                     wr_en_r, wr_en_n;
    logic [ADDR_WIDTH-1:0]    wr_addr_r, wr_addr_n;
    logic [WORD_SIZE-1:0]     wr_data_r, wr_data_n;
    logic                     busy_r;
    logic                     done_r;

    logic signed [ACC_W-1:0]       bias_ext_s;
    logic signed [2*WORD_SIZE-1:0] prod_s;

    // Bias sign-extended to accumulator width; full-precision signed product.
    assign bias_ext_s = ACC_W'($signed(mem_rd_data));
    assign prod_s     = (2*WORD_SIZE)'(x_reg_r) * (2*WORD_SIZE)'($signed(mem_rd_data));

    // Next-state and next-output logic. Strobes and addresses are computed one
    // cycle early so that the registered outputs line up with the state.
    always_comb begin
        state_n   = state_r;
        j_n       = j_r;
        i_n       = i_r;
        wptr_n    = wptr_r;
        acc_n     = acc_r;
        x_reg_n   = x_reg_r;
        x_base_n  = x_base_r;
        b_base_n  = b_base_r;
        z_base_n  = z_base_r;
        rd_en_n   = 1'b0;
        rd_addr_n = rd_addr_r;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_r;
        wr_data_n = wr_data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_base_n  = x_base;
                    b_base_n  = b_base;
                    z_base_n  = z_base;
                    wptr_n    = w_base;
                    j_n       = {JW{1'b0}};
                    i_n       = {IW{1'b0}};
                    rd_en_n   = 1'b1;
                    rd_addr_n = b_base;
                    state_n   = ST_BIAS_RD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BIAS_RD: begin
                state_n = ST_BIAS_CAP;
            end
            ST_BIAS_CAP: begin
                acc_n     = bias_ext_s <<< FRAC;
                rd_en_n   = 1'b1;
                rd_addr_n = x_base_r + ADDR_WIDTH'(i_r);
                state_n   = ST_X_RD;
            end
            ST_X_RD: begin
                // Weight read is issued back-to-back with the input read.
                rd_en_n   = 1'b1;
                rd_addr_n = wptr_r;
                state_n   = ST_W_RD;
            end
            ST_W_RD: begin
                x_reg_n = $signed(mem_rd_data);
                state_n = ST_MAC;
            end
            ST_MAC: begin
                acc_n  = acc_r + ACC_W'(prod_s);
                // Weights are row-major, so one running pointer covers the layer.
                wptr_n = wptr_r + ADDR_WIDTH'(1);
                if (i_r != I_LAST) begin
                    i_n       = i_r + IW'(1);
                    rd_en_n   = 1'b1;
                    rd_addr_n = x_base_r + ADDR_WIDTH'(i_n);
                    state_n   = ST_X_RD;
                end else begin
                    i_n       = {IW{1'b0}};
                    wr_en_n   = 1'b1;
                    wr_addr_n = z_base_r + ADDR_WIDTH'(j_r);
                    wr_data_n = scale_sat(acc_n);
                    state_n   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (j_r == J_LAST) begin
                    state_n = ST_DONE;
                end else begin
                    j_n       = j_r + JW'(1);
                    i_n       = {IW{1'b0}};
                    rd_en_n   = 1'b1;
                    rd_addr_n = b_base_r + ADDR_WIDTH'(j_n);
                    state_n   = ST_BIAS_RD;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output update; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            j_r       <= {JW{1'b0}};
            i_r       <= {IW{1'b0}};
            wptr_r    <= {ADDR_WIDTH{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            x_reg_r   <= {WORD_SIZE{1'b0}};
            x_base_r  <= {ADDR_WIDTH{1'b0}};
            b_base_r  <= {ADDR_WIDTH{1'b0}};
            z_base_r  <= {ADDR_WIDTH{1'b0}};
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {WORD_SIZE{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            j_r       <= j_n;
            i_r       <= i_n;
            wptr_r    <= wptr_n;
            acc_r     <= acc_n;
            x_reg_r   <= x_reg_n;
            x_base_r  <= x_base_n;
            b_base_r  <= b_base_n;
            z_base_r  <= z_base_n;
            rd_en_r   <= rd_en_n;
            rd_addr_r <= rd_addr_n;
            wr_en_r   <= wr_en_n;
            wr_addr_r <= wr_addr_n;
            wr_data_r <= wr_data_n;
            busy_r    <= (state_n != ST_IDLE);
            done_r    <= (state_n == ST_DONE);
        end
    end

    assign mem_rd_en   = rd_en_r;
    assign mem_rd_addr = rd_addr_r;
    assign mem_wr_en   = wr_en_r;
    assign mem_wr_addr = wr_addr_r;
    assign mem_wr_data = wr_data_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_sequencer
//
// Scoreboard bench for fc_layer_sequencer at Q8.8, IP=4, OP=3. Each layer run
// pushes its expected read addresses, writes (address, data, cycle) and done
// timing into queues; an independent monitor pops and compares whenever the
// DUT strobes. Expected Z values are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_fc_layer_sequencer;

    localparam int IP = 4;
    localparam int OP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x_base, w_base, b_base, z_base;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        busy;
    logic        done;

    fc_layer_sequencer #(
        .WORD_SIZE(16), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP),
        .INT_SLICE(8), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_base(x_base), .w_base(w_base), .b_base(b_base), .z_base(z_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle read latency.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  t_start  = 0;
    int  n_vec    = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  rd_cnt   = 0;
    int  wr_cnt   = 0;
    int  mon_cyc;
    ev_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rl(input logic [15:0] v);
`ifdef FC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Expected traffic of one layer: bias read, IP x (X read, W read), write.
    task automatic push_layer(input logic [15:0] xb, input logic [15:0] wb,
                              input logic [15:0] bb, input logic [15:0] zb,
                              input logic [15:0] z0, input logic [15:0] z1,
                              input logic [15:0] z2);
        logic [15:0] zv [3];
        ev_t e;
        int  base;
        zv[0] = z0; zv[1] = z1; zv[2] = z2;
        for (int j = 0; j < OP; j++) begin
            base   = j * 15;
            e.data = 16'h0000;
            e.addr = bb + 16'(j);
            e.cyc  = base + 1;
            rd_q.push_back(e);
            for (int i = 0; i < IP; i++) begin
                e.addr = xb + 16'(i);
                e.cyc  = base + 3 + 3 * i;
                rd_q.push_back(e);
                e.addr = wb + 16'(j * IP + i);
                e.cyc  = base + 4 + 3 * i;
                rd_q.push_back(e);
            end
            e.addr = zb + 16'(j);
            e.data = rl(zv[j]);
            e.cyc  = base + 15;
            wr_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [15:0] xb, input logic [15:0] wb,
                             input logic [15:0] bb, input logic [15:0] zb);
        x_base  = xb; w_base = wb; b_base = bb; z_base = zb;
        start   = 1'b1;
        t_start = edge_no;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int prev;
        prev = done_cnt;
        for (int k = 0; k < 300 && done_cnt == prev; k++) @(negedge clk);
        check("done_seen", 64'(done_cnt - prev), 64'd1);
    endtask

    task automatic wm(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d;
    endtask

    // Monitor: compares every strobe against the scoreboard queues.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            rd_q.delete();
            wr_q.delete();
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            mon_cyc = edge_no - t_start;
            if (mem_rd_en && mem_wr_en) begin
                n_vec++;
                n_fail++;
                $display("FAIL rd_wr_overlap: both strobes high at cycle %0d", mon_cyc);
            end
            if (mem_rd_en) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rd_unexpected: read addr %h, expected no read", mem_rd_addr);
                end else begin
                    mon_e = rd_q.pop_front();
                    check("rd_addr_cycle", {16'h0, mem_rd_addr, 32'(mon_cyc)},
                          {16'h0, mon_e.addr, 32'(mon_e.cyc)});
                end
            end
            if (mem_wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL wr_unexpected: write addr %h data %h, expected no write",
                             mem_wr_addr, mem_wr_data);
                end else begin
                    mon_e = wr_q.pop_front();
                    check("wr_addr_data_cycle", {mem_wr_addr, mem_wr_data, 32'(mon_cyc)},
                          {mon_e.addr, mon_e.data, 32'(mon_e.cyc)});
                end
            end
            if (done) begin
                check("done_cycle", 64'(mon_cyc), 64'd46);
                check("rd_count", 64'(rd_cnt), 64'd27);
                check("wr_count", 64'(wr_cnt), 64'd3);
                check("queues_empty", 64'(rd_q.size() + wr_q.size()), 64'd0);
                rd_cnt = 0;
                wr_cnt = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 65536; k++) mem[16'(k)] = 16'h0000;
        // Region A: basic dot products
        wm(16'h0100, 16'h0100); wm(16'h0101, 16'h0200); wm(16'h0102, 16'h0300); wm(16'h0103, 16'h0400);
        for (int k = 0; k < 4; k++) wm(16'h0200 + 16'(k), 16'h0100);
        wm(16'h0204, 16'h0080); wm(16'h0207, 16'h0040);
        wm(16'h0208, 16'hFF00); wm(16'h0209, 16'hFF00);
        wm(16'h0300, 16'h0080); wm(16'h0301, 16'hFF00); wm(16'h0302, 16'h0000);
        // Region B: saturation
        for (int k = 0; k < 4; k++) begin
            wm(16'h1000 + 16'(k), 16'h7F00);
            wm(16'h1100 + 16'(k), 16'h7F00);
            wm(16'h1104 + 16'(k), 16'h8100);
        end
        wm(16'h1108, 16'h7F00); wm(16'h1109, 16'h8100);
        wm(16'h1202, 16'h0100);
        // Region C: negative results and floor truncation
        wm(16'h2000, 16'h0100); wm(16'h2001, 16'h0001);
        wm(16'h2100, 16'hFB00); wm(16'h2105, 16'hFF80); wm(16'h2109, 16'h0080);
        wm(16'h2202, 16'h0002);
        // Region D: weights wrapping through address 0
        for (int k = 0; k < 4; k++) wm(16'h3000 + 16'(k), 16'h0100);
        for (int k = 0; k < 12; k++) wm(16'hFFFE + 16'(k), 16'(256 * (k + 1)));
        wm(16'h3101, 16'h0001);

        rst_n = 1'b0; start = 1'b0;
        x_base = 16'h0; w_base = 16'h0; b_base = 16'h0; z_base = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run A with ignored start pulses and scrambled bases mid-run
        push_layer(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A80, 16'h0080, 16'hFD00);
        start_run(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        while (edge_no - t_start < 5) @(negedge clk);
        x_base = 16'h5000; w_base = 16'h5100; b_base = 16'h5200; z_base = 16'h5300;
        start = 1'b1; @(negedge clk); start = 1'b0;
        while (edge_no - t_start < 20) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();

        // Run B back-to-back (start in cycle 47 of run A)
        push_layer(16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h7FFF, 16'h8000, 16'h0100);
        start_run(16'h1000, 16'h1100, 16'h1200, 16'h1300);
        wait_done();
        repeat (3) @(negedge clk);

        // Run C: negatives, floor rounding
        push_layer(16'h2000, 16'h2100, 16'h2200, 16'h2300, 16'hFB00, 16'hFFFF, 16'h0002);
        start_run(16'h2000, 16'h2100, 16'h2200, 16'h2300);
        wait_done();
        repeat (2) @(negedge clk);

        // Run D: weight and output addresses wrap
        push_layer(16'h3000, 16'hFFFE, 16'h3100, 16'hFFFF, 16'h0A00, 16'h1A01, 16'h2A00);
        start_run(16'h3000, 16'hFFFE, 16'h3100, 16'hFFFF);
        wait_done();
        repeat (2) @(negedge clk);

        // Run E: reset in the middle of neuron 1
        push_layer(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A80, 16'h0080, 16'hFD00);
        start_run(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        while (edge_no - t_start < 20) @(negedge clk);
        check("pre_reset_writes_left", 64'(wr_q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({busy, done, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);

        // Run F: full layer after reset
        push_layer(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A80, 16'h0080, 16'hFD00);
        start_run(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_done();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
